axis_wait_buffer: RTL

Parametrised store-and-forward AXI-Stream gather block, successor to the fixed 8-word wait block in the accelerator datapath. On an `ex_start` pulse it captures a runtime-selected number of words from the slave stream into an internal register buffer. It then drains the buffer to the master stream, optionally replaying it several times so layer weights can be reused across CNN passes. It marks the end of each pass with `m_last` and flags completion with a `done` pulse.

---
 rtl/axis_wait_buffer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/axis_wait_buffer.sv
// Store-and-forward AXI-Stream gather: captures L words on start, then replays
// them P times to the master stream, flagging each pass end and completion.
module axis_wait_buffer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned LW    = $clog2(DEPTH + 1),
    parameter int unsigned RW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_start,
    input  logic [LW-1:0]    len,
    input  logic [RW-1:0]    reps,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic             startAck,
    output logic             done,
    output logic             busy
);

    localparam int unsigned PW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2,
        CLEAR = 2'd3
    } state_e;

    state_e          state_q;
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [RW-1:0]   pass_q;
    logic [PW-1:0]   last_idx_q;
    logic [RW-1:0]   last_pass_q;
    logic            startack_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [LW-1:0]   len_eff_c;
    logic [PW-1:0]   last_idx_d;
    logic [RW-1:0]   last_pass_d;
    logic            start_ok_c;
    logic            wr_en_c;

    // Start-time terms: clamp len to DEPTH, treat reps=0 as a single pass
    always_comb begin
        len_eff_c   = (len > LW'(DEPTH)) ? LW'(DEPTH) : len;
        last_idx_d  = PW'(len_eff_c - LW'(1));
        last_pass_d = (reps == '0) ? '0 : reps - RW'(1);
        start_ok_c  = ex_start && (len != '0);
    end

    assign wr_en_c = (state_q == FILL) && s_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            pass_q      <= '0;
            last_idx_q  <= '0;
            last_pass_q <= '0;
            startack_q  <= 1'b0;
        end else begin
            startack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_ok_c) begin
                        state_q     <= FILL;
                        last_idx_q  <= last_idx_d;
                        last_pass_q <= last_pass_d;
                        wr_ptr_q    <= '0;
                        rd_ptr_q    <= '0;
                        pass_q      <= '0;
                        startack_q  <= 1'b1;
                    end
                end
                FILL: begin
                    if (s_valid) begin
                        if (wr_ptr_q == last_idx_q) begin
                            wr_ptr_q <= '0;
                            state_q  <= DRAIN;
                        end else begin
                            wr_ptr_q <= wr_ptr_q + PW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (m_ready) begin
                        if (rd_ptr_q == last_idx_q) begin
                            rd_ptr_q <= '0;
                            if (pass_q == last_pass_q) begin
                                pass_q  <= '0;
                                state_q <= CLEAR;
                            end else begin
                                pass_q <= pass_q + RW'(1);
                            end
                        end else begin
                            rd_ptr_q <= rd_ptr_q + PW'(1);
                        end
                    end
                end
                CLEAR: begin
                    state_q  <= IDLE;
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    pass_q   <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Buffer storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (!rst && wr_en_c) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

    assign s_ready  = (state_q == FILL);
    assign m_valid  = (state_q == DRAIN);
    assign m_data   = m_valid ? mem_q[rd_ptr_q] : '0;
    assign m_last   = m_valid && (rd_ptr_q == last_idx_q);
    assign done     = (state_q == CLEAR);
    assign busy     = (state_q != IDLE);
    assign startAck = startack_q;

endmodule
